seg7_scan: RTL and testbench

Time-multiplexed seven-segment driver for the Nexys A7 8-digit display. It takes the packed BCD digit vector produced by the binary-to-BCD stage, where code 10 marks an unused or blank digit. It drives one anode at a time with the decoded cathode pattern, with a dead-time gap between digits to suppress ghosting. The input vector is snapshotted once per frame so a value changing mid-scan never tears on the display.

---
 rtl/seg7_scan_pkg.sv | 10 +
 rtl/bcd_to_seg7.sv | 27 ++
 rtl/seg7_scan.sv | 109 ++++++++++
 tb/tb_seg7_scan.sv | 172 +++++++++++++++++
 4 files changed

// File: rtl/seg7_scan_pkg.sv
// Shared types and constants for the seven-segment display path.
package seg7_scan_pkg;

  typedef logic [6:0] seg7_t;

  localparam logic [3:0] BCD_BLANK = 4'd10;
  localparam seg7_t      SEG_OFF   = 7'h7F;
  localparam seg7_t      SEG_DASH  = 7'h3F;

endpackage

// File: rtl/bcd_to_seg7.sv
// Combinational BCD code to active-low seven-segment pattern (bit 0 = a ... bit 6 = g).
module bcd_to_seg7
  import seg7_scan_pkg::*;
(
  input  logic [3:0] code_i,
  output seg7_t      seg_c_o
);

  always_comb begin
    seg_c_o = SEG_DASH;
    unique case (code_i)
      4'd0:      seg_c_o = 7'h40;
      4'd1:      seg_c_o = 7'h79;
      4'd2:      seg_c_o = 7'h24;
      4'd3:      seg_c_o = 7'h30;
      4'd4:      seg_c_o = 7'h19;
      4'd5:      seg_c_o = 7'h12;
      4'd6:      seg_c_o = 7'h02;
      4'd7:      seg_c_o = 7'h78;
      4'd8:      seg_c_o = 7'h00;
      4'd9:      seg_c_o = 7'h10;
      BCD_BLANK: seg_c_o = SEG_OFF;
      default:   seg_c_o = SEG_DASH;
    endcase
  end

endmodule

// File: rtl/seg7_scan.sv
// Time-multiplexed 8-digit seven-segment driver with per-slot dead time
// and a once-per-frame snapshot of the digit codes.
module seg7_scan
  import seg7_scan_pkg::*;
#(
  parameter int unsigned SCAN_DIV  = 100_000,
  parameter int unsigned BLANK_CYC = 1_000,
  parameter int unsigned DIGITS    = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [DIGITS*4-1:0]   bcd,
  input  logic [DIGITS-1:0]     dp_in,
  input  logic                  en,
  output logic [DIGITS-1:0]     an,
  output logic [6:0]            seg,
  output logic                  dp,
  output logic                  frame_done
);

  localparam int unsigned CNT_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int unsigned IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;

  if (BLANK_CYC == 0 || BLANK_CYC >= SCAN_DIV) begin : g_bad_cfg
    $error("seg7_scan: BLANK_CYC must satisfy 1 <= BLANK_CYC < SCAN_DIV");
  end

  logic [CNT_W-1:0]    slot_cnt_q, slot_cnt_d;
  logic [IDX_W-1:0]    dig_idx_q, dig_idx_d;
  logic [DIGITS*4-1:0] snap_bcd_q, snap_bcd_d;
  logic [DIGITS-1:0]   snap_dp_q, snap_dp_d;
  logic                first_q, first_d;
  logic [DIGITS-1:0]   an_q, an_d;
  seg7_t               seg_q, seg_d;
  logic                dp_q, dp_d;
  logic                frame_done_q, frame_done_d;

  logic                slot_end_c, frame_end_c;
  logic [3:0]          cur_code_c;
  seg7_t               dec_seg_c;

  assign cur_code_c = snap_bcd_q[{dig_idx_q, 2'b00} +: 4];

  bcd_to_seg7 u_dec (
    .code_i  (cur_code_c),
    .seg_c_o (dec_seg_c)
  );

  always_comb begin
    slot_end_c   = (slot_cnt_q == CNT_W'(SCAN_DIV - 1));
    frame_end_c  = slot_end_c && (dig_idx_q == IDX_W'(DIGITS - 1));

    slot_cnt_d   = slot_end_c ? '0 : slot_cnt_q + CNT_W'(1);
    dig_idx_d    = dig_idx_q;
    if (slot_end_c) begin
      dig_idx_d = (dig_idx_q == IDX_W'(DIGITS - 1)) ? '0 : dig_idx_q + IDX_W'(1);
    end

    // Snapshot on the first clock out of reset and at every frame boundary.
    snap_bcd_d   = snap_bcd_q;
    snap_dp_d    = snap_dp_q;
    if (first_q || frame_end_c) begin
      snap_bcd_d = bcd;
      snap_dp_d  = dp_in;
    end
    first_d      = 1'b0;

    an_d         = '1;
    seg_d        = SEG_OFF;
    dp_d         = 1'b1;
    if (en && (slot_cnt_q >= CNT_W'(BLANK_CYC))) begin
      an_d  = ~(DIGITS'(1) << dig_idx_q);
      seg_d = dec_seg_c;
      dp_d  = (cur_code_c == BCD_BLANK) ? 1'b1 : ~snap_dp_q[dig_idx_q];
    end

    frame_done_d = frame_end_c;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      slot_cnt_q   <= '0;
      dig_idx_q    <= '0;
      snap_bcd_q   <= {DIGITS{BCD_BLANK}};
      snap_dp_q    <= '0;
      first_q      <= 1'b1;
      an_q         <= '1;
      seg_q        <= SEG_OFF;
      dp_q         <= 1'b1;
      frame_done_q <= 1'b0;
    end else begin
      slot_cnt_q   <= slot_cnt_d;
      dig_idx_q    <= dig_idx_d;
      snap_bcd_q   <= snap_bcd_d;
      snap_dp_q    <= snap_dp_d;
      first_q      <= first_d;
      an_q         <= an_d;
      seg_q        <= seg_d;
      dp_q         <= dp_d;
      frame_done_q <= frame_done_d;
    end
  end

  assign an         = an_q;
  assign seg        = seg_q;
  assign dp         = dp_q;
  assign frame_done = frame_done_q;

endmodule

// File: tb/tb_seg7_scan.sv
// Randomized bench for seg7_scan checked every cycle against a cycle-count based model.
module tb_seg7_scan;

  localparam int unsigned SCAN_DIV  = 8;
  localparam int unsigned BLANK_CYC = 2;
  localparam int unsigned DIGITS    = 8;
  localparam int unsigned FRAME     = SCAN_DIV * DIGITS;

  logic        clk;
  logic        rst_n;
  logic [31:0] bcd;
  logic [7:0]  dp_in;
  logic        en;
  logic [7:0]  an;
  logic [6:0]  seg;
  logic        dp;
  logic        frame_done;

  int total = 0;
  int bad   = 0;
  int n     = 0;

  logic [6:0]  seg_ref [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                                7'h00, 7'h10, 7'h7F, 7'h3F, 7'h3F, 7'h3F, 7'h3F, 7'h3F};
  logic [31:0] m_bcd;
  logic [7:0]  m_dp;

  seg7_scan #(
    .SCAN_DIV  (SCAN_DIV),
    .BLANK_CYC (BLANK_CYC),
    .DIGITS    (DIGITS)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .bcd        (bcd),
    .dp_in      (dp_in),
    .en         (en),
    .an         (an),
    .seg        (seg),
    .dp         (dp),
    .frame_done (frame_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, n);
    end
  endtask

  // Edge n (1-based since reset release) shows position (n-1) of the 64-cycle frame.
  always @(posedge clk) begin
    logic [7:0] e_an;
    logic [6:0] e_seg;
    logic       e_dp, e_fd;
    logic [3:0] code;
    int         pos, dig, sc;
    if (rst_n) begin
      n     = n + 1;
      pos   = (n - 1) % FRAME;
      dig   = pos / SCAN_DIV;
      sc    = pos % SCAN_DIV;
      e_an  = 8'hFF;
      e_seg = 7'h7F;
      e_dp  = 1'b1;
      if (en && sc >= BLANK_CYC) begin
        code  = m_bcd[dig*4 +: 4];
        e_an  = 8'hFF ^ (8'd1 << dig);
        e_seg = seg_ref[code];
        e_dp  = (code == 4'd10) ? 1'b1 : !m_dp[dig];
      end
      e_fd = (n % FRAME == 0);
      if (n == 1 || n % FRAME == 0) begin
        m_bcd = bcd;
        m_dp  = dp_in;
      end
      #1;
      check("an", 32'(an), 32'(e_an));
      check("seg", 32'(seg), 32'(e_seg));
      check("dp", 32'(dp), 32'(e_dp));
      check("frame_done", 32'(frame_done), 32'(e_fd));
    end else begin
      n = 0;
      #1;
      check("rst_an", 32'(an), 32'hFF);
      check("rst_seg", 32'(seg), 32'h7F);
      check("rst_dp", 32'(dp), 32'd1);
      check("rst_frame_done", 32'(frame_done), 32'd0);
    end
  end

  task automatic wait_n(input int target);
    int guard = 0;
    while (n < target && guard < 2000) begin
      @(negedge clk);
      guard++;
    end
    if (n < target) check("wait_timeout", 32'(n), 32'(target));
  endtask

  task automatic rand_cycles(input int cycles);
    for (int i = 0; i < cycles; i++) begin
      @(negedge clk);
      if ($urandom_range(3) == 0) begin
        bcd   = $urandom;
        dp_in = 8'($urandom);
      end
      if ($urandom_range(15) == 0) en = ~en;
    end
  endtask

  initial begin
    int guard;
    rst_n = 1'b1;
    bcd   = 32'hAAAA1234;
    dp_in = 8'h04;
    en    = 1'b1;
    m_bcd = 32'hAAAAAAAA;
    m_dp  = 8'h00;
    #1 rst_n = 1'b0;
    repeat (5) @(negedge clk);
    rst_n = 1'b1;

    // Mid-frame change must not tear the current frame.
    wait_n(FRAME + 3 * SCAN_DIV + 3);
    bcd = 32'hAAAA5678;

    // Disabled for one whole frame.
    wait_n(3 * FRAME);
    en = 1'b0;
    wait_n(3 * FRAME + 8);
    bcd   = 32'h9876543B;
    dp_in = 8'h00;
    wait_n(4 * FRAME);
    en = 1'b1;

    // Blank digit 0 with its decimal point requested.
    wait_n(4 * FRAME + 40);
    bcd   = 32'h0000000A;
    dp_in = 8'hFF;
    wait_n(6 * FRAME);

    rand_cycles(200);

    // Asynchronous reset mid-slot 5 while driving.
    en = 1'b1;
    guard = 0;
    do begin
      @(negedge clk);
      guard++;
    end while (n % FRAME != 5 * SCAN_DIV + 3 && guard < 200);
    check("slot5_found", 32'(n % FRAME), 32'(5 * SCAN_DIV + 3));
    #2 rst_n = 1'b0;
    #1;
    check("async_an", 32'(an), 32'hFF);
    check("async_seg", 32'(seg), 32'h7F);
    check("async_dp", 32'(dp), 32'd1);
    check("async_frame_done", 32'(frame_done), 32'd0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;

    rand_cycles(150);
    @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
